// File: rtl/stage3_hart_scheduler.sv
// Barrel hart scheduler for the 3-stage pipeline.
// Each advance picks the next eligible hart round-robin, starting after the
// current hart. A per-hart blocked bit keeps stalled harts out of rotation.
// All outputs come straight from flops.
module stage3_hart_scheduler #(
   parameter int NUM_HARTS = 4,
   parameter int HID_W     = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic [NUM_HARTS-1:0] hart_enable,
   input  logic                 block_req,
   input  logic [HID_W-1:0]     block_hart,
   input  logic                 wake_req,
   input  logic [HID_W-1:0]     wake_hart,
   input  logic                 fetch_stall,
   output logic [31:0]          hart_id,
   output logic                 hart_valid,
   output logic [NUM_HARTS-1:0] blocked
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]           state;
   logic [HID_W-1:0]     cur;
   logic [NUM_HARTS-1:0] blocked_next;
   logic [NUM_HARTS-1:0] eligible;
   logic                 found;
   logic [HID_W-1:0]     next_idx;
   int                   cand;

   // Same-cycle blocked update: set first, then clear, so a wake wins over
   // a block on the same hart. Out-of-range indices match no bit.
   always_comb begin
      blocked_next = blocked;
      for (int i = 0; i < NUM_HARTS; i++) begin
         if (block_req && (int'(block_hart) == i)) blocked_next[i] = 1'b1;
      end
      for (int i = 0; i < NUM_HARTS; i++) begin
         if (wake_req && (int'(wake_hart) == i)) blocked_next[i] = 1'b0;
      end
   end

   // Eligibility looks ahead at this cycle's block/wake so a hart blocked
   // now is never picked on the same edge.
   always_comb eligible = hart_enable & ~blocked_next;

   // Next-hart search: lowest index from IDLE, otherwise circular starting
   // at cur+1 and ending at cur, so cur only wins when it is alone.
   always_comb begin
      found    = 1'b0;
      next_idx = cur;
      cand     = 0;
      if (state == IDLE) begin
         for (int i = 0; i < NUM_HARTS; i++) begin
            if (!found && eligible[i]) begin
               found    = 1'b1;
               next_idx = HID_W'(i);
            end
         end
      end else begin
         for (int off = 1; off <= NUM_HARTS; off++) begin
            cand = (int'(cur) + off) % NUM_HARTS;
            if (!found && eligible[cand]) begin
               found    = 1'b1;
               next_idx = HID_W'(cand);
            end
         end
      end
   end

   // Blocked bits track every cycle; selection and state only move when
   // fetch can take a new hart, so an in-flight selection is never revoked.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         blocked <= '0;
         cur     <= '0;
         state   <= IDLE;
      end else begin
         blocked <= blocked_next;
         if (!fetch_stall) begin
            if (found) begin
               cur   <= next_idx;
               state <= RUN;
            end else begin
               state <= IDLE;
            end
         end
      end
   end

   // Fetch sees the index zero-extended to a machine word.
   always_comb begin
      hart_id    = 32'(cur);
      hart_valid = (state == RUN);
   end

endmodule

// File: doc/stage3_hart_scheduler.md
Name: stage3_hart_scheduler

Overview:
- Fine-grained (barrel) hart scheduler for the 3-stage pipeline.
- Each cycle the fetch stage can accept, it picks the next eligible hart round-robin and drives the hart_id the fetch stage consumes.
- Tracks a per-hart blocked bit (set on long-latency events, cleared on completion) so stalled harts are skipped.
- Sits between hart-control sources (CSR enable, memory/hazard logic) and fetch.

Parameters:
- NUM_HARTS, 4, number of hardware harts; legal 1..16.
- HID_W, $clog2(NUM_HARTS) (min 1), width of internal hart index.

Ports:
- CLK  input  1  core clock.
- nRST  input  1  asynchronous active-low reset.
- hart_enable  input  NUM_HARTS  per-hart run enable (bit i = hart i), level.
- block_req  input  1  pulse: set blocked bit of block_hart.
- block_hart  input  HID_W  hart index for block_req.
- wake_req  input  1  pulse: clear blocked bit of wake_hart.
- wake_hart  input  HID_W  hart index for wake_req.
- fetch_stall  input  1  fetch cannot accept a new hart selection this cycle.
- hart_id  output  32  selected hart, zero-extended (word_t), to fetch.
- hart_valid  output  1  hart_id names a hart fetch may issue for.
- blocked  output  NUM_HARTS  current blocked-bit vector (debug/CSR visibility).

Behaviour:
- Reset (nRST low, async):
  - hart_id=0, hart_valid=0, blocked=0, state=IDLE.
  - Reset mid-operation discards all blocked bits immediately.
- Blocked-bit update, every cycle regardless of fetch_stall:
  - blocked_next = blocked, with the bit for block_hart set if block_req, then the bit for wake_hart cleared if wake_req.
  - Block and wake on the same hart in the same cycle: wake wins, bit ends at 0.
  - Indices >= NUM_HARTS are ignored.
- Eligibility: eligible[i] = hart_enable[i] & ~blocked_next[i]. The selection uses the same-cycle blocked update (combinational look-ahead).
- States: IDLE (no hart selected), RUN (hart_valid=1).
- Advance condition: fetch_stall=0. When fetch_stall=1, hart_id, hart_valid and state hold unchanged, even if the current hart becomes blocked or disabled. The in-flight selection completes; the change applies at the next advance.
- IDLE, on advance:
  - If any hart is eligible: hart_id <= lowest-index eligible hart, hart_valid <= 1, go to RUN.
  - Otherwise stay in IDLE.
- RUN, on advance:
  - Search circularly from hart_id+1 (mod NUM_HARTS) through hart_id. The first eligible hart becomes hart_id.
  - The current hart is chosen only if it is the sole eligible hart.
  - If none is eligible: hart_valid <= 0, hart_id holds, go to IDLE.
- Latency: selection is registered; a block/wake/enable change affects hart_id on the next clock edge where fetch_stall=0.
- Wrap-around: index NUM_HARTS-1 wraps to 0.
- NUM_HARTS=1: hart_id is always 0; hart_valid follows eligible[0] on each advance.
- Fairness: with k eligible harts and no stalls, each hart is selected exactly once every k advances.
- Fully synchronous except reset; no combinational path from inputs to outputs.

Test Plan:
- Reset, NUM_HARTS=4, hart_enable=4'b1111, no stalls -> cycle 1 after reset release: hart_id=0, hart_valid=1; following cycles 1,2,3,0,1.
- RUN at hart_id=1, block_req with block_hart=2 in the same cycle -> next hart_id=3 (2 skipped), blocked=4'b0100; wake_req with wake_hart=2 -> hart 2 is selected again after hart 1 on the next rotation.
- fetch_stall=1 for 3 cycles while hart_id=2 and hart 2 gets blocked -> hart_id stays 2 and hart_valid stays 1 during the stall; the first unstalled edge selects 3.
- block_req and wake_req both targeting hart 1 in the same cycle, with hart 1 previously blocked -> blocked[1]=0 and hart 1 remains in rotation.
- hart_enable=4'b0001 -> hart_id=0 every cycle; then all harts disabled -> hart_valid=0 next edge, state IDLE; re-enable 4'b1000 -> hart_id=3, hart_valid=1.
- Assert nRST low mid-rotation with blocked=4'b1010 -> immediately hart_valid=0, hart_id=0, blocked=0; after release, the lowest-index enabled hart is selected.
